// File: rtl/dram_write.sv
// dram_write
// Write side of the row-addressed dram block. A one-cycle strobe (inpb)
// carrying a row address (inp) and a word (din) starts a fixed
// IDLE -> ACT -> WR -> IDLE sequence. The word lands in the row array
// on the WR -> IDLE edge, and outb pulses in the following cycle.
//
// Handshake: inpb is a one-cycle request with no ready signal. It is
// accepted only if the FSM is IDLE at the sampling edge. A request that
// arrives while busy is discarded, and drop pulses for one cycle after
// that edge.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset; clears FSM, outputs and array
//   inpb      write strobe
//   inp       write row address, captured with inpb
//   din       write data, captured with inpb
//   busy      high while a write sequence is in progress
//   outb      one-cycle pulse after a commit
//   drop      one-cycle pulse after a rejected strobe
//   rd_row    read-back row select
//   rd_data   registered read-back data (read-before-write)
//   state_dbg current FSM state, for observation only
module dram_write #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inpb,
  input  logic [ADDR_W-1:0] inp,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              outb,
  output logic              drop,
  input  logic [ADDR_W-1:0] rd_row,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state_dbg
);

  localparam int ROWS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACT  = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   row_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [ROWS];

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      outb    <= 1'b0;
      drop    <= 1'b0;
      rd_data <= '0;
      row_q   <= '0;
      data_q  <= '0;
      for (int i = 0; i < ROWS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      outb <= 1'b0;
      drop <= 1'b0;
      // Non-blocking read sees the array before any commit on this edge.
      rd_data <= mem[rd_row];
      case (state)
        IDLE: begin
          if (inpb) begin
            row_q  <= inp;
            data_q <= din;
            state  <= ACT;
            busy   <= 1'b1;
          end
        end
        ACT: begin
          if (inpb) drop <= 1'b1;
          state <= WR;
          busy  <= 1'b1;
        end
        WR: begin
          // A strobe here is still rejected even though we return to IDLE.
          if (inpb) drop <= 1'b1;
          mem[row_q] <= data_q;
          state      <= IDLE;
          busy       <= 1'b0;
          outb       <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_write.sv
module tb_dram_write;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int ROWS   = 1 << ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              inpb = 1'b0;
  logic [ADDR_W-1:0] inp  = '0;
  logic [DATA_W-1:0] din  = '0;
  logic [ADDR_W-1:0] rd_row = '0;
  logic              busy, outb, drop;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        state_dbg;

  dram_write #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .inpb(inpb), .inp(inp), .din(din),
    .busy(busy), .outb(outb), .drop(drop),
    .rd_row(rd_row), .rd_data(rd_data), .state_dbg(state_dbg)
  );

  // scoreboard: accepted writes queued as {row, data}, popped on outb
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        exp_mem [ROWS];
  int checks   = 0;
  int failures = 0;
  int outb_cnt = 0;
  int drop_cnt = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs sampled 1ns after it. Reset aborts queued work.
  task automatic tick();
    logic [ADDR_W+DATA_W-1:0] e;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < ROWS; i++) exp_mem[i] = '0;
    end
    if (outb === 1'b1) begin
      outb_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL outb_unexpected observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_mem[e[ADDR_W+DATA_W-1:DATA_W]] = e[DATA_W-1:0];
      end
    end
    if (drop === 1'b1) drop_cnt++;
  endtask

  // Present a strobe for one edge; inputs are scrambled afterwards.
  task automatic strobe(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                        input bit accept);
    inpb = 1'b1;
    inp  = r;
    din  = d;
    if (accept) exp_q.push_back({r, d});
    tick();
    inpb = 1'b0;
    inp  = ADDR_W'($urandom_range(0, ROWS - 1));
    din  = $urandom;
  endtask

  task automatic read_row(input logic [ADDR_W-1:0] r, input string tag,
                          input logic [DATA_W-1:0] exp);
    rd_row = r;
    tick();
    chk(tag, rd_data, exp);
    chk({tag, "_model"}, rd_data, exp_mem[r]);
  endtask

  int o0, d0;

  initial begin
    for (int i = 0; i < ROWS; i++) exp_mem[i] = '0;

    // reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outb", 32'(outb), 0);
    chk("rst_drop", 32'(drop), 0);
    for (int i = 0; i < ROWS; i++) read_row(ADDR_W'(i), "rst_row", 32'h0);

    // single write and read-back, rd_row parked on the target
    rd_row = 4'd14;
    tick();
    strobe(4'd14, 32'hDEADBEEF, 1'b1);
    chk("w1_busy_e1", 32'(busy), 1);
    chk("w1_outb_e1", 32'(outb), 0);
    tick();
    chk("w1_busy_e2", 32'(busy), 1);
    chk("w1_outb_e2", 32'(outb), 0);
    tick();
    chk("w1_outb_e3", 32'(outb), 1);
    chk("w1_busy_e3", 32'(busy), 0);
    chk("w1_rd_e3_old", rd_data, 32'h0);
    tick();
    chk("w1_rd_e4", rd_data, 32'hDEADBEEF);
    chk("w1_outb_e4", 32'(outb), 0);
    read_row(4'd13, "w1_row13", 32'h0);

    // back-to-back at 3-cycle spacing
    o0 = outb_cnt;
    d0 = drop_cnt;
    strobe(4'd0, 32'd1, 1'b1);
    tick();
    tick();
    chk("b2b_outb1", 32'(outb), 1);
    strobe(4'd12, 32'd2, 1'b1);
    chk("b2b_busy2", 32'(busy), 1);
    tick();
    tick();
    chk("b2b_outb2", 32'(outb), 1);
    strobe(4'd2, 32'd3, 1'b1);
    tick();
    tick();
    chk("b2b_outb3", 32'(outb), 1);
    chk("b2b_outb_cnt", 32'(outb_cnt - o0), 3);
    chk("b2b_no_drop", 32'(drop_cnt - d0), 0);
    read_row(4'd0,  "b2b_row0",  32'd1);
    read_row(4'd12, "b2b_row12", 32'd2);
    read_row(4'd2,  "b2b_row2",  32'd3);

    // overlap at k+1
    strobe(4'd5, 32'hA5A5A5A5, 1'b1);
    strobe(4'd9, 32'hFFFFFFFF, 1'b0);
    chk("ovl_drop_e2", 32'(drop), 1);
    tick();
    chk("ovl_drop_e3", 32'(drop), 0);
    chk("ovl_outb_e3", 32'(outb), 1);
    read_row(4'd5, "ovl_row5", 32'hA5A5A5A5);
    read_row(4'd9, "ovl_row9", 32'h0);

    // overlap at k+2: dropped although the FSM returns to IDLE there
    strobe(4'd6, 32'h00000066, 1'b1);
    tick();
    strobe(4'd7, 32'h00000077, 1'b0);
    chk("ovl2_drop", 32'(drop), 1);
    chk("ovl2_outb", 32'(outb), 1);
    chk("ovl2_busy", 32'(busy), 0);
    read_row(4'd7, "ovl2_row7", 32'h0);
    read_row(4'd6, "ovl2_row6", 32'h00000066);

    // overwrite with same-edge read-back
    rd_row = 4'd8;
    strobe(4'd8, 32'd7, 1'b1);
    tick();
    tick();
    chk("ow_outb1", 32'(outb), 1);
    strobe(4'd8, 32'd9, 1'b1);
    chk("ow_rd_e4", rd_data, 32'd7);
    tick();
    tick();
    chk("ow_outb2", 32'(outb), 1);
    chk("ow_rd_commit_edge", rd_data, 32'd7);
    tick();
    chk("ow_rd_after", rd_data, 32'd9);

    // reset mid-operation
    o0 = outb_cnt;
    strobe(4'd4, 32'h00001234, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_outb", 32'(outb), 0);
    tick();
    tick();
    tick();
    chk("mid_no_outb", 32'(outb_cnt - o0), 0);
    read_row(4'd4,  "mid_row4",  32'h0);
    read_row(4'd14, "mid_row14", 32'h0);
    strobe(4'd4, 32'h00005678, 1'b1);
    tick();
    tick();
    chk("mid_fresh_outb", 32'(outb), 1);
    read_row(4'd4, "mid_fresh_row4", 32'h00005678);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_write.md
# dram_write

Write-side companion to the row-addressed `dram` read block. It accepts a one-cycle write strobe carrying a 4-bit row address and a 32-bit word, then runs a fixed three-cycle activate/write sequence. It commits the word into a 16 × 32 row array and pulses a completion flag. A registered read-back port exposes the array contents, so benches and the read path can confirm what was committed.

## Interface
- `ADDR_W`, 4, row address width; the array holds 2^ADDR_W rows.
- `DATA_W`, 32, row word width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `inpb`  in  1  write strobe; sampled each rising edge.
- `inp`  in  ADDR_W  write row address; sampled with `inpb`.
- `din`  in  DATA_W  write data; sampled with `inpb`.
- `busy`  out  1  high while a write sequence is in progress.
- `outb`  out  1  one-cycle pulse when a write has committed.
- `drop`  out  1  one-cycle pulse when a strobe is rejected because the block is busy.
- `rd_row`  in  ADDR_W  read-back row select.
- `rd_data`  out  DATA_W  registered read-back data.

## Operation
- FSM states: IDLE, ACT, WR.
  - IDLE → ACT on `inpb`=1. Latch `inp` into `row_q` and `din` into `data_q`.
  - ACT → WR unconditionally.
  - WR → IDLE unconditionally. On the WR→IDLE edge, `mem[row_q]` ← `data_q`.
- `busy` = (state ≠ IDLE), registered with the state.
- `outb` is registered: 1 for exactly the cycle after the WR→IDLE edge, else 0.
- A strobe is accepted only when the state is IDLE at the sampling edge.
- If `inpb`=1 while the state is ACT or WR:
  - the strobe is ignored;
  - `drop` pulses 1 in the following cycle;
  - the latched `row_q`/`data_q` are unchanged.
- Rows are written only through the WR commit. Nothing else writes the array, apart from the reset clear.
- Read-back: every edge, `rd_data` ← `mem[rd_row]`. It uses the array value before any commit on the same edge (read-before-write).
- Reset (`rst`=1 at an edge):
  - state → IDLE;
  - `busy`, `outb`, `drop` → 0;
  - `rd_data` → 0;
  - `row_q`, `data_q` → 0;
  - all array rows → 0.
- Reset has priority over everything, including an in-flight write. An aborted sequence commits nothing and does not pulse `outb`.

## Timing
- A strobe is sampled at edge k with the state IDLE:
  - the cycle after k: `busy`=1 (state ACT);
  - edge k+1: state WR;
  - edge k+2: commit, state IDLE; in the cycle after k+2, `busy`=0 and `outb`=1.
- Write latency is 3 edges, strobe to `outb`.
- The earliest next accepted strobe is at edge k+3, so the sustained rate is one write per 3 cycles. This matches the read path's 3-cycle request spacing.
- Read-back latency is 1 edge.
  - A commit at edge k+2 to row r is visible on `rd_data` (with `rd_row`=r) after edge k+3, not after k+2.
- A strobe at edge k+3 can coincide with the `outb` cycle. It is accepted; the new sequence and the old pulse do not interact.
- A strobe at edge k+1 or k+2 is dropped, with `drop` pulsing in the cycle after that edge. A strobe at k+2 is dropped even though the state becomes IDLE at that edge.
- Reset at edge k+1 or k+2 of a sequence: no commit, and the target row reads 0 afterwards.
- Address and data are captured only at the accept edge. Changing `inp`/`din` during ACT/WR has no effect.

## Test plan
- **Reset values:** hold `rst`=1 for 2 cycles, then scan `rd_row` 0..15. Required: every `rd_data`=0, and `busy`=`outb`=`drop`=0.
- **Single write and read-back:** strobe `inp`=14, `din`=32'hDEADBEEF at edge 1. Required:
  - `busy`=1 after edges 1 and 2;
  - `outb`=1 only after edge 3;
  - with `rd_row`=14, `rd_data`=32'hDEADBEEF after edge 4;
  - row 13 still reads 0.
- **Back-to-back at 3-cycle spacing:** strobes to rows 0, 12, 2 with data 1, 2, 3 at edges 1, 4, 7. Required: three `outb` pulses (after edges 3, 6, 9), no `drop`, and read-back 1/2/3.
- **Overlap:** strobe row 5, data 32'hA5A5A5A5 at edge 1, then a strobe to row 9, data 32'hFFFFFFFF at edge 2. Required:
  - `drop`=1 after edge 2;
  - row 5 = 32'hA5A5A5A5;
  - row 9 = 0.
- **Overwrite with same-edge read-back:** write row 8 = 7, then write row 8 = 9, holding `rd_row`=8 throughout. Required: `rd_data` reads 7 in the cycle after the second commit edge, then 9 one edge later.
- **Reset mid-operation:** strobe row 4, data 32'h1234 at edge 1, then `rst`=1 at edge 2. Required: no `outb` pulse, `busy`=0 after edge 2, row 4 reads 0, and a fresh write to row 4 succeeds normally.
